// File: rtl/icv_pkg.sv
// Shared definitions for the CANsec ICV generator (TX) and checker (RX).
// Contents: AES-128 S-box and round constants, FSM state encoding, block/ICV widths,
// and small GF(2^8) helpers used by the iterative round datapath.
package icv_pkg;

  localparam int unsigned AES_BLK    = 128;
  localparam int unsigned ICV_MAX    = 128;
  localparam logic [3:0]  LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StCmp  = 2'd2
  } icv_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Round constant for rounds 1..10; anything else yields zero.
  function automatic logic [7:0] rcon_of(input logic [3:0] round);
    if (round == 4'd0 || round > LAST_ROUND) begin
      return 8'h00;
    end
    return RCON[round - 4'd1];
  endfunction

endpackage

// File: rtl/icv_verify_if.sv
// Request/result bundle between the RX frame controller (master) and icv_verify (slave).
//  start/clear      : control from the frame controller
//  blk_a/blk_b      : received header and payload digests
//  rx_icv           : ICV field from the frame, ICV_BITS wide
//  busy/done        : checker status; done is a one-cycle result strobe
//  icv_ok/icv_calc  : comparison result and computed ciphertext
//  err_cnt          : saturating mismatch count, present only with ICV_ERR_CNT_EN
interface icv_verify_if #(
  parameter int unsigned ICV_BITS = icv_pkg::ICV_MAX
);
  logic                          start;
  logic                          clear;
  logic [icv_pkg::AES_BLK-1:0]   blk_a;
  logic [icv_pkg::AES_BLK-1:0]   blk_b;
  logic [ICV_BITS-1:0]           rx_icv;
  logic                          busy;
  logic                          done;
  logic                          icv_ok;
  logic [icv_pkg::AES_BLK-1:0]   icv_calc;
`ifdef ICV_ERR_CNT_EN
  logic [15:0]                   err_cnt;

  modport master (
    output start, clear, blk_a, blk_b, rx_icv,
    input  busy, done, icv_ok, icv_calc, err_cnt
  );
  modport slave (
    input  start, clear, blk_a, blk_b, rx_icv,
    output busy, done, icv_ok, icv_calc, err_cnt
  );
`else
  modport master (
    output start, clear, blk_a, blk_b, rx_icv,
    input  busy, done, icv_ok, icv_calc
  );
  modport slave (
    input  start, clear, blk_a, blk_b, rx_icv,
    output busy, done, icv_ok, icv_calc
  );
`endif
endinterface

// File: rtl/icv_verify_round.sv
// aes_round_comb: one combinational AES-128 encryption round plus key expansion step.
//  state      : current cipher state (bit 127 = state byte 0, column-major)
//  round_key  : key of the previous round
//  rcon       : round constant for the round being computed
//  last       : final round, MixColumns is skipped
//  next_state : SubBytes, ShiftRows, [MixColumns], AddRoundKey(next_key)
//  next_key   : expanded key for this round
module aes_round_comb
  import icv_pkg::*;
(
  input  logic [AES_BLK-1:0] state,
  input  logic [AES_BLK-1:0] round_key,
  input  logic [7:0]         rcon,
  input  logic               last,
  output logic [AES_BLK-1:0] next_state,
  output logic [AES_BLK-1:0] next_key
);

  logic [31:0] w0, w1, w2, w3, tmp;
  logic [31:0] k0, k1, k2, k3;
  logic [7:0]  sb [16];
  logic [7:0]  sr [16];
  logic [7:0]  mc [16];

  // Key expansion: RotWord + SubWord on the last word, then a running XOR chain.
  always_comb begin
    w0  = round_key[127:96];
    w1  = round_key[95:64];
    w2  = round_key[63:32];
    w3  = round_key[31:0];
    tmp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    k0  = w0 ^ tmp;
    k1  = w1 ^ k0;
    k2  = w2 ^ k1;
    k3  = w3 ^ k2;
  end

  assign next_key = {k0, k1, k2, k3};

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = SBOX[state[127-8*i -: 8]];
    end
  end

  // Byte index is 4*col + row; row r rotates left by r columns.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  always_comb begin
    next_state = '0;
    for (int i = 0; i < 16; i++) begin
      next_state[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ next_key[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/icv_verify.sv
// icv_verify: receive-side CANsec integrity check for CAN-XL.
// Encrypts blk_a ^ blk_b with AES-128 under KEY (one round per clock, single shared round
// datapath) and compares the top ICV_BITS of the ciphertext with the frame's ICV.
//  clk, g_rst : clock; asynchronous active-high reset
//  bus        : icv_verify_if slave (start/clear/blk_a/blk_b/rx_icv in;
//               busy/done/icv_ok/icv_calc out)
// Build option: define ICV_ERR_CNT_EN to add bus.err_cnt, a 16-bit saturating count of
// mismatching results, cleared only by g_rst.
module icv_verify
  import icv_pkg::*;
#(
  parameter logic [AES_BLK-1:0] KEY      = 128'h3c4fcf0984d901fa3248c273efa53945,
  parameter int unsigned        ICV_BITS = 128
) (
  input logic         clk,
  input logic         g_rst,
  icv_verify_if.slave bus
);

  icv_state_e          state;
  logic [3:0]          round;
  logic [AES_BLK-1:0]  st;
  logic [AES_BLK-1:0]  rk;
  logic [ICV_BITS-1:0] rx_lat;
  logic                done_q;
  logic                icv_ok_q;
  logic [AES_BLK-1:0]  icv_calc_q;

  logic [AES_BLK-1:0]  st_nxt;
  logic [AES_BLK-1:0]  rk_nxt;
  logic [7:0]          rcon;
  logic                last_round;
  logic                icv_match;

  assign rcon       = rcon_of(round);
  assign last_round = (round == LAST_ROUND);
  assign icv_match  = (st[AES_BLK-1 -: ICV_BITS] == rx_lat);

  aes_round_comb u_round (
    .state      (st),
    .round_key  (rk),
    .rcon       (rcon),
    .last       (last_round),
    .next_state (st_nxt),
    .next_key   (rk_nxt)
  );

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      state      <= StIdle;
      round      <= 4'd0;
      st         <= '0;
      rk         <= '0;
      rx_lat     <= '0;
      done_q     <= 1'b0;
      icv_ok_q   <= 1'b0;
      icv_calc_q <= '0;
    end else if (bus.clear) begin
      // Abort wins over everything, including a start in the same cycle.
      state      <= StIdle;
      round      <= 4'd0;
      done_q     <= 1'b0;
      icv_ok_q   <= 1'b0;
      icv_calc_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            st         <= bus.blk_a ^ bus.blk_b ^ KEY;
            rk         <= KEY;
            round      <= 4'd1;
            rx_lat     <= bus.rx_icv;
            icv_ok_q   <= 1'b0;
            icv_calc_q <= '0;
            state      <= StRun;
          end
        end
        StRun: begin
          st <= st_nxt;
          rk <= rk_nxt;
          if (last_round) begin
            round <= 4'd0;
            state <= StCmp;
          end else begin
            round <= round + 4'd1;
          end
        end
        StCmp: begin
          icv_calc_q <= st;
          icv_ok_q   <= icv_match;
          done_q     <= 1'b1;
          state      <= StIdle;
        end
        default: begin
          state <= StIdle;
          round <= 4'd0;
        end
      endcase
    end
  end

  assign bus.busy     = (state != StIdle);
  assign bus.done     = done_q;
  assign bus.icv_ok   = icv_ok_q;
  assign bus.icv_calc = icv_calc_q;

`ifdef ICV_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Counts exactly the done strobes that report a mismatch; a cleared CMP produces no done.
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      err_cnt_q <= '0;
    end else if (state == StCmp && !bus.clear && !icv_match && err_cnt_q != 16'hffff) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_icv_verify.sv
// Bench for icv_verify: two instances (FIPS-197 key / 128-bit ICV, default key / 64-bit ICV)
// share stimulus; results are compared against an AES-128 model built from GF(2^8) arithmetic.
module tb_icv_verify;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] DEF_KEY  = 128'h3c4fcf0984d901fa3248c273efa53945;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk   = 1'b0;
  logic         g_rst = 1'b0;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic [127:0] blk_a = '0;
  logic [127:0] blk_b = '0;
  logic [127:0] rx_f  = '0;
  logic [63:0]  rx_d  = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err_f = 0;
  int exp_err_d = 0;

  logic [7:0] sb [256];

  always #5 clk = ~clk;

  icv_verify_if #(.ICV_BITS(128)) f_if ();
  icv_verify_if #(.ICV_BITS(64))  d_if ();

  assign f_if.start  = start;
  assign f_if.clear  = clear;
  assign f_if.blk_a  = blk_a;
  assign f_if.blk_b  = blk_b;
  assign f_if.rx_icv = rx_f;
  assign d_if.start  = start;
  assign d_if.clear  = clear;
  assign d_if.blk_a  = blk_a;
  assign d_if.blk_b  = blk_b;
  assign d_if.rx_icv = rx_d;

  icv_verify #(.KEY(FIPS_KEY), .ICV_BITS(128)) dut_f (.clk(clk), .g_rst(g_rst), .bus(f_if));
  icv_verify #(.KEY(DEF_KEY),  .ICV_BITS(64))  dut_d (.clk(clk), .g_rst(g_rst), .bus(d_if));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   w [176];
    logic [7:0]   tw [4];
    logic [7:0]   rc;
    logic [127:0] out;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ w[i];
    end
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tw[j] = w[i-4+j];
      if (i % 16 == 0) begin
        tw[0] = sb[w[i-3]] ^ rc;
        tw[1] = sb[w[i-2]];
        tw[2] = sb[w[i-1]];
        tw[3] = sb[w[i-4]];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tw[j];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
      if (r != 10) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int q = 0; q < 4; q++)
            s[4*c+q] = gmul(t[4*c+q], 8'h02) ^ gmul(t[4*c+(q+1)%4], 8'h03)
                       ^ t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    out = '0;
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    int           lat;
    logic [127:0] calc_f;
    logic [127:0] calc_d;
    logic         ok_f;
    logic         ok_d;
    logic         done_d;
    logic         busy_10;
    logic         busy_done;
  } res_t;

  // Issue one start (optionally in the current cycle) and wait for done, bounded.
  task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic [127:0] rf,
                        input logic [63:0] rd, input bit now, output res_t r);
    if (!now) @(negedge clk);
    blk_a = a;
    blk_b = b;
    rx_f  = rf;
    rx_d  = rd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    blk_a = rnd128();
    blk_b = rnd128();
    rx_f  = ~rf;
    rx_d  = ~rd;
    r.lat = -1;
    r.calc_f = '0;
    r.calc_d = '0;
    r.ok_f = 1'b0;
    r.ok_d = 1'b0;
    r.done_d = 1'b0;
    r.busy_10 = 1'b0;
    r.busy_done = 1'b1;
    for (int k = 1; k <= 30 && r.lat < 0; k++) begin
      @(negedge clk);
      if (k == 10) r.busy_10 = f_if.busy & d_if.busy;
      if (f_if.done) begin
        r.lat       = k;
        r.calc_f    = f_if.icv_calc;
        r.calc_d    = d_if.icv_calc;
        r.ok_f      = f_if.icv_ok;
        r.ok_d      = d_if.icv_ok;
        r.done_d    = d_if.done;
        r.busy_done = f_if.busy | d_if.busy;
      end
    end
  endtask

  task automatic check_op(input string tag, input logic [127:0] a, input logic [127:0] b,
                          input logic [127:0] mf, input logic [63:0] md, input logic eok_f,
                          input logic eok_d, input bit now, input bit hold);
    logic [127:0] ref_f;
    logic [127:0] ref_d;
    res_t r;
    ref_f = aes_enc(FIPS_KEY, a ^ b);
    ref_d = aes_enc(DEF_KEY, a ^ b);
    run_op(a, b, ref_f ^ mf, ref_d[127:64] ^ md, now, r);
    chk({tag, ".latency"}, 128'(r.lat), 128'(11));
    chk({tag, ".busy_r10"}, 128'(r.busy_10), 128'(1));
    chk({tag, ".busy_at_done"}, 128'(r.busy_done), 128'(0));
    chk({tag, ".done_d"}, 128'(r.done_d), 128'(1));
    chk({tag, ".calc_f"}, r.calc_f, ref_f);
    chk({tag, ".calc_d"}, r.calc_d, ref_d);
    chk({tag, ".ok_f"}, 128'(r.ok_f), 128'(eok_f));
    chk({tag, ".ok_d"}, 128'(r.ok_d), 128'(eok_d));
    if (!eok_f) exp_err_f++;
    if (!eok_d) exp_err_d++;
`ifdef ICV_ERR_CNT_EN
    chk({tag, ".err_cnt_f"}, 128'(f_if.err_cnt), 128'(exp_err_f));
    chk({tag, ".err_cnt_d"}, 128'(d_if.err_cnt), 128'(exp_err_d));
`endif
    if (hold) begin
      repeat (2) @(negedge clk);
      chk({tag, ".done_pulse"}, 128'(f_if.done), 128'(0));
      chk({tag, ".ok_f_held"}, 128'(f_if.icv_ok), 128'(eok_f));
      chk({tag, ".calc_d_held"}, d_if.icv_calc, ref_d);
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (f_if.done || d_if.done) n++;
    end
  endtask

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] mf;
    logic [63:0]  md;
    logic         ok_f;
    logic         ok_d;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] mf;
    logic [63:0]  md;
    logic [127:0] ref_f;
    logic [127:0] ref_d;
    res_t r;
    int n;

    build_sbox();

    tbl[0] = '{FIPS_PT, 128'h0, 128'h0, 64'h0, 1'b1, 1'b1};
    tbl[1] = '{FIPS_PT, 128'h0, 128'h1, 64'h0, 1'b0, 1'b1};
    tbl[2] = '{128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
               128'h0000000000000000a5a5a5a5a5a5a5a5, 64'h0, 1'b0, 1'b1};
    tbl[3] = '{128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
               128'h0, 64'h8000000000000000, 1'b1, 1'b0};
    tbl[4] = '{128'hdeadbeef0123456789abcdeffedcba98, 128'h55aa55aa00ff00ff1234567887654321,
               {1'b1, 127'h0}, 64'h1, 1'b0, 1'b0};

    // Reset state.
    #2 g_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.busy", 128'(f_if.busy | d_if.busy), 128'(0));
    chk("rst.done", 128'(f_if.done | d_if.done), 128'(0));
    chk("rst.icv_ok", 128'(f_if.icv_ok | d_if.icv_ok), 128'(0));
    chk("rst.icv_calc", f_if.icv_calc | d_if.icv_calc, 128'h0);
`ifdef ICV_ERR_CNT_EN
    chk("rst.err_cnt", 128'(f_if.err_cnt | d_if.err_cnt), 128'(0));
`endif
    g_rst = 1'b0;

    // Table vectors.
    for (int i = 0; i < 5; i++) begin
      check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].mf, tbl[i].md,
               tbl[i].ok_f, tbl[i].ok_d, 1'b0, 1'b1);
      if (i == 0) chk("fips197_ct", f_if.icv_calc, FIPS_CT);
    end

    // Randomised operations.
    for (int i = 0; i < 6; i++) begin
      a  = rnd128();
      b  = rnd128();
      mf = ($urandom_range(1) == 0) ? 128'h0 : (128'h1 << $urandom_range(127));
      md = ($urandom_range(1) == 0) ? 64'h0 : (64'h1 << $urandom_range(63));
      check_op($sformatf("rnd%0d", i), a, b, mf, md, mf == 128'h0, md == 64'h0, 1'b0, 1'b1);
    end

    // Start accepted in the cycle done is high.
    a = rnd128();
    b = rnd128();
    check_op("chain1", a, b, 128'h0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_op("chain2", b, FIPS_PT, 128'h0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Start pulsed at cycle 4 of a busy run is ignored.
    a = rnd128();
    b = rnd128();
    ref_f = aes_enc(FIPS_KEY, a ^ b);
    ref_d = aes_enc(DEF_KEY, a ^ b);
    @(negedge clk);
    blk_a = a;
    blk_b = b;
    rx_f  = ref_f;
    rx_d  = ref_d[127:64];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    blk_a = rnd128();
    blk_b = rnd128();
    rx_f  = '0;
    rx_d  = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_dones(30, n);
    chk("busy_start.dones", 128'(n), 128'(1));
    chk("busy_start.calc_f", f_if.icv_calc, ref_f);
    chk("busy_start.ok_f", 128'(f_if.icv_ok), 128'(1));
    chk("busy_start.calc_d", d_if.icv_calc, ref_d);

    // Clear at round 5.
    @(negedge clk);
    blk_a = rnd128();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("clear.busy_before", 128'(f_if.busy), 128'(1));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear.busy", 128'(f_if.busy | d_if.busy), 128'(0));
    chk("clear.icv_ok", 128'(f_if.icv_ok | d_if.icv_ok), 128'(0));
    chk("clear.icv_calc", f_if.icv_calc | d_if.icv_calc, 128'h0);
    count_dones(20, n);
    chk("clear.no_done", 128'(n), 128'(0));

    // Start together with clear: stays idle.
    @(negedge clk);
    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    chk("start_clear.busy", 128'(f_if.busy | d_if.busy), 128'(0));
    count_dones(15, n);
    chk("start_clear.no_done", 128'(n), 128'(0));

    // g_rst at round 3.
    @(negedge clk);
    blk_a = rnd128();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 g_rst = 1'b1;
    #1;
    chk("grst.busy", 128'(f_if.busy | d_if.busy), 128'(0));
    chk("grst.done", 128'(f_if.done | d_if.done), 128'(0));
    chk("grst.icv_ok", 128'(f_if.icv_ok | d_if.icv_ok), 128'(0));
    chk("grst.icv_calc", f_if.icv_calc | d_if.icv_calc, 128'h0);
    exp_err_f = 0;
    exp_err_d = 0;
`ifdef ICV_ERR_CNT_EN
    chk("grst.err_cnt", 128'(f_if.err_cnt | d_if.err_cnt), 128'(0));
`endif
    @(negedge clk);
    g_rst = 1'b0;
    count_dones(20, n);
    chk("grst.no_done", 128'(n), 128'(0));

    // Recovery after reset.
    check_op("post_rst", rnd128(), rnd128(), 128'h0, 64'h4, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
